// File: rtl/fpu_pkg.sv
// Shared FPU constants: op codes, sequencer state encoding, fflags bit positions.
// The FPU decoder imports the same package so op codes stay consistent.
package fpu_pkg;

  localparam logic [4:0] FPU_FADD  = 5'd0;
  localparam logic [4:0] FPU_FSUB  = 5'd1;
  localparam logic [4:0] FPU_FMUL  = 5'd2;
  localparam logic [4:0] FPU_FDIV  = 5'd3;
  localparam logic [4:0] FPU_UNSUP = 5'd31;

  // fcsr.fflags bit positions
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  // Only the four arithmetic ops reach the datapath; every other code is illegal.
  function automatic logic op_supported(input logic [4:0] op);
    case (op)
      FPU_FADD, FPU_FSUB, FPU_FMUL, FPU_FDIV: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// Bundles the core request, datapath handshake and register-file writeback
// signals of the FPU sequencer. master = core/datapath side, slave = sequencer.
interface fpu_sequencer_if #(
  parameter int XLEN = 32
) ();

  // request from decoder / FP register-file read stage
  logic            fpu_en;
  logic [4:0]      fpu_op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            flush;
  // core control
  logic            stall;
  logic            busy;
  logic            illegal_instr;
  // datapath handshake
  logic            fpu_start;
  logic [4:0]      fpu_op_o;
  logic [XLEN-1:0] fpu_a;
  logic [XLEN-1:0] fpu_b;
  logic            fpu_done;
  logic [XLEN-1:0] fpu_result;
  logic [4:0]      fpu_flags;
  // writeback
  logic            frf_we;
  logic [4:0]      frf_waddr;
  logic [XLEN-1:0] frf_wdata;
  logic            fflags_we;
  logic [4:0]      fflags_o;
  logic            timeout_err;

  modport master (
    output fpu_en, fpu_op, rs1_val, rs2_val, rd_addr, flush,
    output fpu_done, fpu_result, fpu_flags,
    input  stall, busy, illegal_instr,
    input  fpu_start, fpu_op_o, fpu_a, fpu_b,
    input  frf_we, frf_waddr, frf_wdata, fflags_we, fflags_o, timeout_err
  );

  modport slave (
    input  fpu_en, fpu_op, rs1_val, rs2_val, rd_addr, flush,
    input  fpu_done, fpu_result, fpu_flags,
    output stall, busy, illegal_instr,
    output fpu_start, fpu_op_o, fpu_a, fpu_b,
    output frf_we, frf_waddr, frf_wdata, fflags_we, fflags_o, timeout_err
  );

endinterface

// File: rtl/fpu_watchdog.sv
// Cycle counter bounding how long the sequencer waits for the datapath.
// expired is high while the count sits at TIMEOUT_CYCLES-1.
module fpu_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count_reg;

  // count up while enabled, restart from zero on clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expired = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_sequencer.sv
// Sequences the multi-cycle FPU datapath for the single-cycle RV32F core:
// accept request, pulse start, stall until done or watchdog expiry, write back.
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input logic            clk,
  input logic            rst,
  fpu_sequencer_if.slave bus
);

  state_t          state_reg;
  state_t          state_next;

  logic [4:0]      op_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      flags_reg;
  logic            ok_reg;

  logic            accept;
  logic            supported;
  logic            wd_clear;
  logic            wd_enable;
  logic            wd_expired;
  logic            write_en;

  assign supported = op_supported(bus.fpu_op);
  // a flush in IDLE squashes the instruction, so it is never accepted
  assign accept    = (state_reg == IDLE) && bus.fpu_en && supported && !bus.flush;

  fpu_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // request latch and result capture; operands stay stable from ISSUE through WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      rd_reg     <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      ok_reg     <= 1'b0;
    end else begin
      if (accept) begin
        op_reg <= bus.fpu_op;
        a_reg  <= bus.rs1_val;
        b_reg  <= bus.rs2_val;
        rd_reg <= bus.rd_addr;
      end
      if (state_reg == WAIT) begin
        if (bus.fpu_done) begin
          result_reg <= bus.fpu_result;
          flags_reg  <= bus.fpu_flags;
          ok_reg     <= 1'b1;
        end else begin
          ok_reg     <= 1'b0;
        end
      end
    end
  end

  // next-state and control outputs; done beats watchdog expiry, flush beats both
  always_comb begin
    state_next        = state_reg;
    wd_clear          = 1'b0;
    wd_enable         = 1'b0;
    write_en          = 1'b0;
    bus.stall         = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.fpu_start     = 1'b0;
    bus.timeout_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          bus.stall  = 1'b1;
          state_next = ISSUE;
        end else if (bus.fpu_en && !supported && !bus.flush) begin
          bus.illegal_instr = 1'b1;
        end
      end
      ISSUE: begin
        bus.stall     = 1'b1;
        bus.fpu_start = 1'b1;
        wd_clear      = 1'b1;
        state_next    = bus.flush ? IDLE : WAIT;
      end
      WAIT: begin
        bus.stall = 1'b1;
        wd_enable = 1'b1;
        if (bus.flush) begin
          state_next = IDLE;
        end else if (bus.fpu_done || wd_expired) begin
          state_next = WB;
        end
      end
      WB: begin
        state_next = IDLE;
        if (!bus.flush) begin
          write_en        = ok_reg;
          bus.timeout_err = !ok_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.fpu_op_o  = op_reg;
  assign bus.fpu_a     = a_reg;
  assign bus.fpu_b     = b_reg;
  assign bus.frf_we    = write_en;
  assign bus.fflags_we = write_en;
  assign bus.frf_waddr = write_en ? rd_reg : '0;
  assign bus.frf_wdata = write_en ? result_reg : '0;
  assign bus.fflags_o  = write_en ? flags_reg : '0;

endmodule

// File: doc/fpu_sequencer.md
Name: fpu_sequencer

Overview:
Sequences the multi-cycle FPU execution unit on behalf of the single-cycle RV32F core. Takes the decoded FPU request (enable plus 5-bit op code) and the operand values, then issues a one-cycle start to the FPU datapath. Holds the core stalled until the datapath signals done or a watchdog expires, then writes the result and exception flags back. It sits between the FPU decoder/register-file read stage and the FPU datapath.

Parameters:
XLEN, 32, operand/result width
TIMEOUT_CYCLES, 64, max WAIT cycles before abort (>=2)
CNT_W, $clog2(TIMEOUT_CYCLES)+1, watchdog counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
fpu_en  in  1  decoded FPU instruction present this cycle
fpu_op  in  5  decoded op: 0 FADD, 1 FSUB, 2 FMUL, 3 FDIV, 31 unsupported
rs1_val  in  XLEN  operand A from FP register file
rs2_val  in  XLEN  operand B
rd_addr  in  5  destination FP register
flush  in  1  synchronous abort (trap/redirect)
stall  out  1  hold PC/instruction (combinational)
busy  out  1  state != IDLE
illegal_instr  out  1  one-cycle pulse, unsupported FPU op
fpu_start  out  1  one-cycle start pulse to datapath
fpu_op_o  out  5  latched op to datapath
fpu_a  out  XLEN  latched operand A
fpu_b  out  XLEN  latched operand B
fpu_done  in  1  datapath result valid (single-cycle pulse)
fpu_result  in  XLEN  datapath result
fpu_flags  in  5  NV,DZ,OF,UF,NX
frf_we  out  1  FP register file write enable
frf_waddr  out  5  write address
frf_wdata  out  XLEN  write data
fflags_we  out  1  accumulate flags into fcsr.fflags
fflags_o  out  5  flags to accumulate
timeout_err  out  1  one-cycle pulse, watchdog expired

Behaviour:
- Reset (async, any state): state=IDLE. All registered outputs 0: fpu_start, fpu_op_o, fpu_a, fpu_b, frf_we, frf_waddr, frf_wdata, fflags_we, fflags_o, timeout_err, illegal_instr. Watchdog counter=0. A reset mid-operation discards the op; no writeback occurs.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - fpu_en & op in {0..3}: latch op, rs1_val, rs2_val, rd_addr, then go to ISSUE.
  - fpu_en & op==31: illegal_instr=1 for this cycle (combinational), no stall, no write, stay in IDLE.
  - op values 4..30 are treated as unsupported, same as 31.
- ISSUE: fpu_start=1 for exactly this cycle. Clear the watchdog, go to WAIT. fpu_done is ignored in ISSUE.
- WAIT: the watchdog increments each cycle.
  - fpu_done=1: capture fpu_result and fpu_flags, go to WB with ok=1.
  - Otherwise, if count==TIMEOUT_CYCLES-1: go to WB with ok=0.
  - If done and expiry occur in the same cycle, done wins.
- WB (one cycle):
  - ok=1: frf_we=1, frf_waddr=latched rd, frf_wdata=result, fflags_we=1, fflags_o=flags.
  - ok=0: timeout_err=1, no writes.
  - Go to IDLE.
- stall = (IDLE & fpu_en & supported op) | ISSUE | WAIT. stall=0 in WB, so the core retires the instruction at the end of the WB edge. The next IDLE cycle therefore sees the next instruction and never re-triggers.
- Latency: request at cycle 0, start at cycle 1, done at cycle 1+k (k>=1), writeback at cycle 2+k. The core stalls for 2+k cycles.
- flush (sync) in ISSUE/WAIT/WB: go to IDLE next edge, suppress write and flags. A late fpu_done arriving in IDLE is ignored.
- flush in IDLE: blocks acceptance in that cycle; stall=0.
- fpu_op_o, fpu_a and fpu_b stay stable from ISSUE through WB.

Decomposition:
- Shared package fpu_pkg:
  - op code constants FPU_FADD=0, FPU_FSUB=1, FPU_FMUL=2, FPU_FDIV=3, FPU_UNSUP=31.
  - state encoding IDLE/ISSUE/WAIT/WB.
  - fflags bit indices NV=4, DZ=3, OF=2, UF=1, NX=0.
  - The decoder shares the same constants.
- One natural sub-module: fpu_watchdog (clear, enable, expire at TIMEOUT_CYCLES-1).

Test Plan:
- FADD, rd=5, rs1=0x3F800000, rs2=0x40000000; model done 3 cycles after start with result 0x40400000, flags 0 -> stall high for cycles 0-4, fpu_start only at cycle 1, frf_we at cycle 5 with addr 5, data 0x40400000.
- fpu_en with op=31 -> illegal_instr pulse, stall=0, fpu_start never asserted, frf_we=0.
- FDIV, model never returns done, TIMEOUT_CYCLES=64 -> timeout_err pulse in cycle 66, no frf_we/fflags_we, state returns to IDLE, stall drops.
- FDIV 1.0/0.0 (rs2=0x00000000); done with result 0x7F800000, flags 0b01000 -> fflags_we=1, fflags_o=0b01000 in WB.
- Assert rst mid-WAIT; deliver fpu_done after reset release -> all outputs 0 immediately, no write, busy=0.
- flush in WAIT; done arrives the next cycle -> no write. A back-to-back FMUL issued right after is accepted and completes normally.
